paddle_ctrl: RTL and testbench
==============================

Name: paddle_ctrl

Overview:
- Consumes the keyboard stage's move_left/move_right/level outputs and turns them into the Breakout paddle's horizontal position.
- Updates once per video frame (frame_tick), with hold-to-accelerate, a level-dependent speed cap and hard clamping at the playfield edges.
- paddle_x feeds the renderer and the ball-collision logic.

Parameters:
- SCREEN_W, 640, playfield width in pixels
- PADDLE_W, 64, paddle width in pixels
- X_RESET, 288, paddle_x after reset (centred)
- BASE_SPEED, 2, pixels/frame on first held frame
- MAX_SPEED, 8, speed cap before level bonus
- ACCEL_FRAMES, 4, held frames per +1 speed step

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-CLK pulse per frame
- move_left  in  1  level, 1 while 'a' held
- move_right  in  1  level, 1 while 'd' held
- level  in  4  game level, 1..8
- paddle_x  out  10  left edge of paddle, 0..SCREEN_W-PADDLE_W
- paddle_dir  out  2  00 idle, 01 left, 10 right (current FSM state)
- speed  out  4  current pixels/frame, 0 when idle
- edge_hit  out  1  one-CLK pulse when a move is clamped at an edge

Behaviour:
- Reset (async, RST=1): paddle_x=X_RESET, paddle_dir=00, speed=0, edge_hit=0, hold counter=0, synchronisers cleared. Reset mid-move abandons the move immediately.
- Inputs: move_left/move_right pass through 2-flop synchronisers on CLK. All decisions use the synchronised values in the frame_tick cycle.
- Sampled command: L = sl & ~sr, R = sr & ~sl. Both or neither held = IDLE.
- FSM states IDLE, LEFT, RIGHT. Transitions are evaluated only on frame_tick; the state holds between ticks.
  - IDLE: L goes to LEFT, R goes to RIGHT. Entering a move sets speed=BASE_SPEED and hold counter=0.
  - LEFT/RIGHT: same direction stays and accelerates. Opposite direction switches state with speed reset to BASE_SPEED. No command goes to IDLE with speed=0 and counter=0.
- Movement: on each frame_tick where the next state is LEFT/RIGHT, paddle_x moves by the speed in effect for that tick.
  - The first tick of a move uses BASE_SPEED.
  - paddle_x is valid 1 CLK after the frame_tick edge (registered).
- Acceleration:
  - The hold counter increments on each moving tick.
  - When the counter reaches ACCEL_FRAMES it wraps to 0 and speed increments, effective from the next tick.
  - Cap = MAX_SPEED + level[3:1]. level=0 is treated as 1; values >8 are treated as 8.
  - Speed never exceeds the cap; the counter keeps wrapping once capped.
- Arithmetic:
  - Use 11-bit signed intermediate x_next = paddle_x ± speed.
  - Left clamp: x_next<0 gives 0.
  - Right clamp: x_next > SCREEN_W-PADDLE_W (576) gives 576.
  - A clamp that changes x_next, or a move requested while already at the bound, pulses edge_hit for 1 CLK, coincident with the paddle_x update.
  - Speed and state still update at a bound; no wrap-around is ever allowed.
- Between frame_ticks, all outputs hold. A frame_tick asserted on consecutive CLKs is processed as separate ticks.
- paddle_dir and speed reflect the registered state after each tick.

Test Plan:
- Reset, no keys, 10 frame_ticks -> paddle_x=288, paddle_dir=00, speed=0, edge_hit never 1.
- move_right held, ticks 1-4 -> paddle_x 290,292,294,296. Tick 5 -> speed=3, paddle_x=299. Tick 9 -> speed=4.
- level=8, move_right held 60 ticks -> speed saturates at 12, never 13; paddle_x clamps at 576 with edge_hit pulse; further ticks keep 576 with edge_hit pulsing each tick.
- Start paddle_x=3 (left held from reset until reached), left at speed 2 -> next tick gives 1, then 0 with edge_hit=1; no underflow to 1023.
- Both keys held from reset speed 5 mid-move -> next tick paddle_dir=00, speed=0, paddle_x unchanged. Right to left reversal -> speed=2 on first left tick.
- Assert RST asynchronously mid-move (between CLK edges, paddle_x=400) -> outputs return to 288/00/0 immediately without waiting for CLK. Resume on first tick after release.

Source files
------------

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : paddle_ctrl
// Description : Breakout paddle horizontal position controller. Turns the
//               keyboard stage's move_left/move_right levels into a paddle
//               x position, updated once per frame_tick, with
//               hold-to-accelerate, a level-dependent speed cap and hard
//               clamping at the playfield edges.
//
// Ports       : CLK         system clock
//               RST         asynchronous active-high reset
//               frame_tick  one-CLK pulse per video frame
//               move_left   level, high while 'a' held (asynchronous)
//               move_right  level, high while 'd' held (asynchronous)
//               level       game level 1..8 (0 -> 1, >8 -> 8)
//               paddle_x    left edge of paddle, 0..SCREEN_W-PADDLE_W
//               paddle_dir  00 idle, 01 left, 10 right
//               speed       current pixels/frame, 0 when idle
//               edge_hit    one-CLK pulse when a move is clamped at an edge
//
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int PADDLE_W     = 64,
    parameter int X_RESET      = 288,
    parameter int BASE_SPEED   = 2,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic [3:0] level,
    output logic [9:0] paddle_x,
    output logic [1:0] paddle_dir,
    output logic [3:0] speed,
    output logic       edge_hit
);

    localparam int                 c_CW    = $clog2(ACCEL_FRAMES + 1);
    localparam logic signed [10:0] c_X_MAX = 11'(SCREEN_W - PADDLE_W);

    // Encodings double as the paddle_dir output value.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LEFT  = 2'b01,
        S_RIGHT = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]      r_sync_l;
    logic [1:0]      r_sync_r;
    state_t          r_state;
    logic [9:0]      r_x;
    logic [3:0]      r_speed;
    logic [c_CW-1:0] r_cnt;
    logic            r_edge;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [9:0]         w_x_nxt;
    logic [3:0]         w_speed_nxt;
    logic [c_CW-1:0]    w_cnt_nxt;
    logic               w_edge_nxt;

    logic               w_cmd_l;
    logic               w_cmd_r;
    logic [3:0]         w_lvl;
    logic [3:0]         w_cap;
    logic [3:0]         w_eff;
    logic [c_CW-1:0]    w_cnt_base;
    logic [c_CW-1:0]    w_cnt_inc;
    logic signed [10:0] w_xsum;

    // Both keys or neither key held is treated as no command.
    assign w_cmd_l = r_sync_l[1] & ~r_sync_r[1];
    assign w_cmd_r = r_sync_r[1] & ~r_sync_l[1];

    // Level saturated into 1..8 before deriving the speed bonus.
    always_comb begin
        w_lvl = level;
        if (level == 4'd0) begin
            w_lvl = 4'd1;
        end else if (level > 4'd8) begin
            w_lvl = 4'd8;
        end
    end

    assign w_cap = 4'(MAX_SPEED) + {1'b0, w_lvl[3:1]};

    // ------------------------------------------------------------------
    // State register and synchronisers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync_l <= 2'b00;
            r_sync_r <= 2'b00;
            r_state  <= S_IDLE;
            r_x      <= 10'(X_RESET);
            r_speed  <= 4'd0;
            r_cnt    <= '0;
            r_edge   <= 1'b0;
        end else begin
            r_sync_l <= {r_sync_l[0], move_left};
            r_sync_r <= {r_sync_r[0], move_right};
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_speed  <= w_speed_nxt;
            r_cnt    <= w_cnt_nxt;
            r_edge   <= w_edge_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, movement and acceleration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_speed_nxt = r_speed;
        w_cnt_nxt   = r_cnt;
        w_edge_nxt  = 1'b0;
        w_eff       = r_speed;
        w_cnt_base  = r_cnt;
        w_cnt_inc   = r_cnt;
        w_xsum      = $signed({1'b0, r_x});

        if (frame_tick) begin
            if (!w_cmd_l && !w_cmd_r) begin
                w_state_nxt = S_IDLE;
                w_speed_nxt = 4'd0;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = w_cmd_l ? S_LEFT : S_RIGHT;

                // Entering a move or reversing restarts at base speed.
                if (r_state != w_state_nxt) begin
                    w_eff      = 4'(BASE_SPEED);
                    w_cnt_base = '0;
                end else begin
                    w_eff      = r_speed;
                    w_cnt_base = r_cnt;
                end
                // A level drop mid-move can lower the cap below current speed.
                if (w_eff > w_cap) begin
                    w_eff = w_cap;
                end

                // Speed bump takes effect from the following tick.
                w_cnt_inc = w_cnt_base + 1'b1;
                if (w_cnt_inc == c_CW'(ACCEL_FRAMES)) begin
                    w_cnt_nxt   = '0;
                    w_speed_nxt = (w_eff >= w_cap) ? w_cap : w_eff + 4'd1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_speed_nxt = w_eff;
                end

                // Signed 11-bit sum so an underflow is visible as negative.
                if (w_cmd_l) begin
                    w_xsum = $signed({1'b0, r_x}) - $signed({7'b0, w_eff});
                end else begin
                    w_xsum = $signed({1'b0, r_x}) + $signed({7'b0, w_eff});
                end

                // Speed is always >= 1 here, so a move requested while sitting
                // on a bound always lands outside it and is flagged too.
                if (w_xsum < 11'sd0) begin
                    w_x_nxt    = 10'd0;
                    w_edge_nxt = 1'b1;
                end else if (w_xsum > c_X_MAX) begin
                    w_x_nxt    = c_X_MAX[9:0];
                    w_edge_nxt = 1'b1;
                end else begin
                    w_x_nxt    = w_xsum[9:0];
                end
            end
        end
    end

    assign paddle_x   = r_x;
    assign paddle_dir = r_state;
    assign speed      = r_speed;
    assign edge_hit   = r_edge;

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_paddle_ctrl
// Description : Self-checking bench for paddle_ctrl. A frame-level reference
//               model (plain integer arithmetic) predicts position, direction,
//               speed and edge flag after every frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_ctrl;

    localparam int X_MAX = 576;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic [3:0] level = 4'd1;
    logic [9:0] paddle_x;
    logic [1:0] paddle_dir;
    logic [3:0] speed;
    logic       edge_hit;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_x, m_dir, m_spd, m_cnt;
    bit m_edge;

    paddle_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .frame_tick (frame_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .level      (level),
        .paddle_x   (paddle_x),
        .paddle_dir (paddle_dir),
        .speed      (speed),
        .edge_hit   (edge_hit)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_x = 288; m_dir = 0; m_spd = 0; m_cnt = 0; m_edge = 0;
    endtask

    // One frame of the game rules: direction 1 = left, 2 = right.
    task automatic model_step(input bit l, input bit r, input int lvl);
        int d, lv, cap, eff, cnt, nx;
        m_edge = 0;
        d = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
        if (d == 0) begin
            m_dir = 0; m_spd = 0; m_cnt = 0;
        end else begin
            lv  = (lvl == 0) ? 1 : ((lvl > 8) ? 8 : lvl);
            cap = 8 + lv / 2;
            if (m_dir != d) begin eff = 2; cnt = 0; end
            else            begin eff = m_spd; cnt = m_cnt; end
            if (eff > cap) eff = cap;
            cnt++;
            m_spd = eff;
            if (cnt == 4) begin
                cnt = 0;
                m_spd = (eff + 1 > cap) ? cap : eff + 1;
            end
            m_cnt = cnt;
            nx = (d == 1) ? m_x - eff : m_x + eff;
            if (nx < 0)     begin nx = 0;     m_edge = 1; end
            if (nx > X_MAX) begin nx = X_MAX; m_edge = 1; end
            m_x = nx;
            m_dir = d;
        end
    endtask

    // Starts and ends on a falling edge; keys need three edges to get
    // through the input synchronisers.
    task automatic set_keys(input bit l, input bit r, input int lvl);
        move_left = l; move_right = r; level = 4'(lvl);
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
    endtask

    // keep=1 leaves frame_tick high so the next call is a back-to-back tick.
    task automatic apply_tick(input bit keep);
        frame_tick = 1'b1;
        @(posedge CLK);
        model_step(move_left, move_right, int'(level));
        @(negedge CLK);
        if (!keep) frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({paddle_x, paddle_dir, speed, edge_hit} !== {10'd288, 2'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got x=%0d dir=%0d spd=%0d edge=%0b, want 288/0/0/0",
                     paddle_x, paddle_dir, speed, edge_hit);
        end
        set_keys(0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            apply_tick(0);
            checks++;
            if ({paddle_x, paddle_dir, speed, edge_hit} !== {10'd288, 2'd0, 4'd0, 1'b0}) begin
                errors++;
                $display("FAIL idle_tick%0d: got x=%0d dir=%0d spd=%0d edge=%0b, want 288/0/0/0",
                         i, paddle_x, paddle_dir, speed, edge_hit);
            end
        end
    endtask

    task automatic test_accel();
        int xs[1:9];
        int sp[1:9];
        do_reset();
        set_keys(0, 1, 1);
        for (int i = 1; i <= 9; i++) begin
            apply_tick(0);
            xs[i] = int'(paddle_x);
            sp[i] = int'(speed);
            checks++;
            if ({paddle_x, paddle_dir, speed, edge_hit} !==
                {10'(m_x), 2'(m_dir), 4'(m_spd), m_edge}) begin
                errors++;
                $display("FAIL accel_tick%0d: got x=%0d dir=%0d spd=%0d edge=%0b, want %0d/%0d/%0d/%0b",
                         i, paddle_x, paddle_dir, speed, edge_hit, m_x, m_dir, m_spd, m_edge);
            end
        end
        checks++;
        if (xs[1] != 290 || xs[4] != 296 || xs[5] != 299 || sp[5] != 3 || sp[9] != 4) begin
            errors++;
            $display("FAIL accel_profile: got x1=%0d x4=%0d x5=%0d s5=%0d s9=%0d, want 290/296/299/3/4",
                     xs[1], xs[4], xs[5], sp[5], sp[9]);
        end
        // Outputs must hold between ticks.
        repeat (4) @(negedge CLK);
        checks++;
        if ({paddle_x, speed, edge_hit} !== {10'(m_x), 4'(m_spd), 1'b0}) begin
            errors++;
            $display("FAIL accel_hold: got x=%0d spd=%0d edge=%0b, want %0d/%0d/0",
                     paddle_x, speed, edge_hit, m_x, m_spd);
        end
    endtask

    task automatic test_cap_clamp();
        int max_spd = 0;
        do_reset();
        set_keys(0, 1, 8);
        for (int i = 0; i < 60; i++) begin
            apply_tick(0);
            if (int'(speed) > max_spd) max_spd = int'(speed);
            checks++;
            if ({paddle_x, paddle_dir, speed, edge_hit} !==
                {10'(m_x), 2'(m_dir), 4'(m_spd), m_edge}) begin
                errors++;
                $display("FAIL cap_tick%0d: got x=%0d dir=%0d spd=%0d edge=%0b, want %0d/%0d/%0d/%0b",
                         i, paddle_x, paddle_dir, speed, edge_hit, m_x, m_dir, m_spd, m_edge);
            end
        end
        checks++;
        if (max_spd != 12 || paddle_x !== 10'd576 || edge_hit !== 1'b1) begin
            errors++;
            $display("FAIL cap_final: got maxspd=%0d x=%0d edge=%0b, want 12/576/1",
                     max_spd, paddle_x, edge_hit);
        end
        @(negedge CLK);
        checks++;
        if (edge_hit !== 1'b0) begin
            errors++;
            $display("FAIL edge_pulse_width: got edge=%0b one clock later, want 0", edge_hit);
        end
    endtask

    task automatic test_left_clamp();
        int guard = 0;
        do_reset();
        set_keys(1, 0, 1);
        while (!(m_x == 0 && m_edge) && guard < 200) begin
            apply_tick(0);
            guard++;
            checks++;
            if ({paddle_x, paddle_dir, speed, edge_hit} !==
                {10'(m_x), 2'(m_dir), 4'(m_spd), m_edge} || paddle_x > 10'd576) begin
                errors++;
                $display("FAIL left_tick%0d: got x=%0d dir=%0d spd=%0d edge=%0b, want %0d/%0d/%0d/%0b",
                         guard, paddle_x, paddle_dir, speed, edge_hit, m_x, m_dir, m_spd, m_edge);
            end
        end
        apply_tick(0);
        checks++;
        if (guard >= 200 || paddle_x !== 10'd0 || edge_hit !== 1'b1) begin
            errors++;
            $display("FAIL left_bound: got x=%0d edge=%0b ticks=%0d, want 0/1 within 200",
                     paddle_x, edge_hit, guard);
        end
    endtask

    task automatic test_both_reverse();
        int guard = 0;
        logic [9:0] x_before;
        do_reset();
        set_keys(0, 1, 1);
        while (m_spd != 5 && guard < 50) begin
            apply_tick(0);
            guard++;
        end
        x_before = paddle_x;
        checks++;
        if (guard >= 50 || speed !== 4'd5 || paddle_x !== 10'(m_x)) begin
            errors++;
            $display("FAIL reach_speed5: got spd=%0d x=%0d, want 5/%0d", speed, paddle_x, m_x);
        end
        set_keys(1, 1, 1);
        apply_tick(0);
        checks++;
        if ({paddle_x, paddle_dir, speed, edge_hit} !== {x_before, 2'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL both_keys: got x=%0d dir=%0d spd=%0d edge=%0b, want %0d/0/0/0",
                     paddle_x, paddle_dir, speed, edge_hit, x_before);
        end
        set_keys(0, 1, 1);
        repeat (6) apply_tick(0);
        set_keys(1, 0, 1);
        apply_tick(0);
        checks++;
        if (paddle_dir !== 2'b01 || speed !== 4'd2 || paddle_x !== 10'(m_x)) begin
            errors++;
            $display("FAIL reversal: got dir=%0d spd=%0d x=%0d, want 1/2/%0d",
                     paddle_dir, speed, paddle_x, m_x);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        do_reset();
        set_keys(0, 1, 8);
        while (m_x < 400 && guard < 50) begin
            apply_tick(0);
            guard++;
        end
        // Assert reset between clock edges and look before any rising edge.
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({paddle_x, paddle_dir, speed, edge_hit} !== {10'd288, 2'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got x=%0d dir=%0d spd=%0d edge=%0b, want 288/0/0/0",
                     paddle_x, paddle_dir, speed, edge_hit);
        end
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        set_keys(0, 1, 8);
        apply_tick(0);
        checks++;
        if ({paddle_x, paddle_dir, speed, edge_hit} !== {10'd290, 2'd2, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL resume_after_reset: got x=%0d dir=%0d spd=%0d edge=%0b, want 290/2/2/0",
                     paddle_x, paddle_dir, speed, edge_hit);
        end
    endtask

    task automatic test_back_to_back();
        int n, gap, k;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            k = int'($urandom_range(0, 9));
            set_keys(k < 4, (k >= 3 && k < 8), int'($urandom_range(0, 15)));
            n = int'($urandom_range(1, 4));
            for (int j = 0; j < n; j++) begin
                apply_tick(j != n - 1);
                checks++;
                if ({paddle_x, paddle_dir, speed, edge_hit} !==
                    {10'(m_x), 2'(m_dir), 4'(m_spd), m_edge}) begin
                    errors++;
                    $display("FAIL rand_it%0d_t%0d: got x=%0d dir=%0d spd=%0d edge=%0b, want %0d/%0d/%0d/%0b",
                             it, j, paddle_x, paddle_dir, speed, edge_hit, m_x, m_dir, m_spd, m_edge);
                end
            end
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(negedge CLK);
                m_edge = 0;
                checks++;
                if ({paddle_x, paddle_dir, speed, edge_hit} !==
                    {10'(m_x), 2'(m_dir), 4'(m_spd), m_edge}) begin
                    errors++;
                    $display("FAIL rand_hold%0d: got x=%0d dir=%0d spd=%0d edge=%0b, want %0d/%0d/%0d/0",
                             it, paddle_x, paddle_dir, speed, edge_hit, m_x, m_dir, m_spd);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        test_reset();
        test_accel();
        test_cap_clamp();
        test_left_clamp();
        test_both_reverse();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
